// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor: pulses the PLL reset, qualifies a synchronized lock,
// retries on timeout and raises sys_ready once lock has been stable long enough.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_in,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_ready,
    output logic       lock_fail,
    output logic       lost_lock,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_PULSE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t          state_r;
    logic            meta_r;
    logic            lock_s;
    logic [RW-1:0]   rst_cnt_r;
    logic [SW-1:0]   stable_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [1:0]      retry_r;
    logic            pll_rst_r;
    logic            sys_ready_r;
    logic            lock_fail_r;
    logic            lost_lock_r;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_r <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta_r <= pll_locked_in;
            lock_s <= meta_r;
        end
    end

    // Sequencer FSM with its counters and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r      <= ST_RESET;
            rst_cnt_r    <= {RW{1'b0}};
            stable_cnt_r <= {SW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
            retry_r      <= 2'd0;
            pll_rst_r    <= 1'b1;
            sys_ready_r  <= 1'b0;
            lock_fail_r  <= 1'b0;
            lost_lock_r  <= 1'b0;
        end else begin
            lost_lock_r <= 1'b0;
            case (state_r)
                ST_RESET: begin
                    // relock_req is deliberately ignored so the pulse is never stretched
                    pll_rst_r   <= 1'b1;
                    sys_ready_r <= 1'b0;
                    tmo_cnt_r   <= {TW{1'b0}};
                    if (rst_cnt_r == RST_LAST) begin
                        rst_cnt_r <= {RW{1'b0}};
                        pll_rst_r <= 1'b0;
                        state_r   <= ST_WAIT_LOCK;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (relock_req) begin
                        retry_r   <= 2'd0;
                        rst_cnt_r <= {RW{1'b0}};
                        pll_rst_r <= 1'b1;
                        state_r   <= ST_RESET;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rst_cnt_r <= {RW{1'b0}};
                        pll_rst_r <= 1'b1;
                        if (retry_r < RETRY_MAX) begin
                            retry_r <= retry_r + 2'd1;
                            state_r <= ST_RESET;
                        end else begin
                            lock_fail_r <= 1'b1;
                            state_r     <= ST_FAIL;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                        if (lock_s) begin
                            stable_cnt_r <= {SW{1'b0}};
                            state_r      <= ST_STABLE;
                        end else begin
                            state_r <= ST_WAIT_LOCK;
                        end
                    end
                end
                ST_STABLE: begin
                    // Reaching full stability wins over a coincident timeout
                    if (relock_req) begin
                        retry_r   <= 2'd0;
                        rst_cnt_r <= {RW{1'b0}};
                        pll_rst_r <= 1'b1;
                        state_r   <= ST_RESET;
                    end else if (lock_s && (stable_cnt_r == STABLE_LAST)) begin
                        stable_cnt_r <= {SW{1'b0}};
                        sys_ready_r  <= 1'b1;
                        state_r      <= ST_RUN;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rst_cnt_r <= {RW{1'b0}};
                        pll_rst_r <= 1'b1;
                        if (retry_r < RETRY_MAX) begin
                            retry_r <= retry_r + 2'd1;
                            state_r <= ST_RESET;
                        end else begin
                            lock_fail_r <= 1'b1;
                            state_r     <= ST_FAIL;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                        if (lock_s) begin
                            stable_cnt_r <= stable_cnt_r + SW'(1);
                        end else begin
                            stable_cnt_r <= {SW{1'b0}};
                            state_r      <= ST_WAIT_LOCK;
                        end
                    end
                end
                ST_RUN: begin
                    if (relock_req) begin
                        retry_r     <= 2'd0;
                        rst_cnt_r   <= {RW{1'b0}};
                        pll_rst_r   <= 1'b1;
                        sys_ready_r <= 1'b0;
                        state_r     <= ST_RESET;
                    end else if (!lock_s) begin
                        lost_lock_r <= 1'b1;
                        retry_r     <= 2'd0;
                        rst_cnt_r   <= {RW{1'b0}};
                        pll_rst_r   <= 1'b1;
                        sys_ready_r <= 1'b0;
                        state_r     <= ST_RESET;
                    end else begin
                        sys_ready_r <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    pll_rst_r   <= 1'b1;
                    sys_ready_r <= 1'b0;
                    if (relock_req) begin
                        lock_fail_r <= 1'b0;
                        retry_r     <= 2'd0;
                        rst_cnt_r   <= {RW{1'b0}};
                        state_r     <= ST_RESET;
                    end else begin
                        state_r <= ST_FAIL;
                    end
                end
                default: begin
                    rst_cnt_r   <= {RW{1'b0}};
                    pll_rst_r   <= 1'b1;
                    sys_ready_r <= 1'b0;
                    state_r     <= ST_RESET;
                end
            endcase
        end
    end

    assign pll_rst     = pll_rst_r;
    assign sys_ready   = sys_ready_r;
    assign lock_fail   = lock_fail_r;
    assign lost_lock   = lost_lock_r;
    assign retry_count = retry_r;
    assign state       = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

    localparam int RPC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int MR  = 2;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked_in;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_ready;
    logic       lock_fail;
    logic       lost_lock;
    logic [1:0] retry_count;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (RPC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .MAX_RETRIES        (MR)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked_in(pll_locked_in),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .sys_ready    (sys_ready),
        .lock_fail    (lock_fail),
        .lost_lock    (lost_lock),
        .retry_count  (retry_count),
        .state        (state)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges until pll_rst drops, counted from the edge that started the pulse
    task automatic measure_pulse(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (sys_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_leave_lock_states(output int n);
        n = 0;
        while ((state === 3'd1 || state === 3'd2) && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        rst           = 1'b1;
        pll_locked_in = 1'b0;
        relock_req    = 1'b0;
        repeat (3) tick();
        check_val("rst_state", state, 32'd0);
        check_val("rst_pll_rst", pll_rst, 32'd1);
        check_val("rst_sys_ready", sys_ready, 32'd0);
        check_val("rst_lock_fail", lock_fail, 32'd0);
        check_val("rst_lost_lock", lost_lock, 32'd0);
        check_val("rst_retry", retry_count, 32'd0);

        // Power-up sequence: pulse length and ready latency
        rst = 1'b0;
        measure_pulse(n);
        check_val("first_pulse_len", n, RPC);
        check_val("first_wait_state", state, 32'd1);
        tick();
        tick();
        pll_locked_in = 1'b1;
        wait_ready(n);
        check_val("ready_latency", n, LSC + 3);
        check_val("run_state", state, 32'd3);
        check_val("run_retry", retry_count, 32'd0);
        check_val("run_pll_rst", pll_rst, 32'd0);

        // Lock loss in RUN
        pll_locked_in = 1'b0;
        n = 0;
        while (lost_lock !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_val("lost_lock_latency", n, 32'd3);
        check_val("lost_sys_ready", sys_ready, 32'd0);
        check_val("lost_state", state, 32'd0);
        check_val("lost_pll_rst", pll_rst, 32'd1);
        tick();
        check_val("lost_lock_one_cycle", lost_lock, 32'd0);
        measure_pulse(n);
        check_val("lost_pulse_len", n + 1, RPC);

        // Timeouts with lock held low: two retries then FAIL
        for (int a = 0; a <= MR; a++) begin
            wait_leave_lock_states(n);
            check_val("timeout_len", n, LTC);
            if (a < MR) begin
                check_val("retry_state", state, 32'd0);
                check_val("retry_count_step", retry_count, a + 1);
                measure_pulse(n);
                check_val("retry_pulse_len", n, RPC);
            end else begin
                check_val("fail_state", state, 32'd4);
                check_val("fail_flag", lock_fail, 32'd1);
                check_val("fail_pll_rst", pll_rst, 32'd1);
                check_val("fail_retry", retry_count, MR);
            end
        end
        repeat (5) tick();
        check_val("fail_hold_state", state, 32'd4);
        check_val("fail_hold_pll_rst", pll_rst, 32'd1);
        check_val("fail_hold_ready", sys_ready, 32'd0);

        // Recovery from FAIL via relock_req with lock present
        pll_locked_in = 1'b1;
        repeat (3) tick();
        check_val("fail_ignores_lock", state, 32'd4);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check_val("relock_state", state, 32'd0);
        check_val("relock_lock_fail", lock_fail, 32'd0);
        check_val("relock_retry", retry_count, 32'd0);
        measure_pulse(n);
        check_val("relock_pulse_len", n, RPC);
        wait_ready(n);
        check_val("relock_ready_latency", n, LSC + 1);

        // relock_req coincident with lock_s falling in RUN, then relock_req during RESET
        pll_locked_in = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        check_val("coinc_lost_lock", lost_lock, 32'd0);
        check_val("coinc_state", state, 32'd0);
        check_val("coinc_ready", sys_ready, 32'd0);
        tick();
        check_val("coinc_lost_lock_next", lost_lock, 32'd0);
        tick();
        relock_req = 1'b0;
        measure_pulse(m);
        check_val("reset_relock_pulse_len", m + 2, RPC);

        // One-cycle lock glitch at stable count 5
        pll_locked_in = 1'b1;
        repeat (6) tick();
        pll_locked_in = 1'b0;
        tick();
        pll_locked_in = 1'b1;
        tick();
        check_val("glitch_still_stable", state, 32'd2);
        tick();
        check_val("glitch_back_to_wait", state, 32'd1);
        wait_ready(n);
        check_val("glitch_ready_latency", n, LSC + 1);

        // Timeout keeps running across STABLE -> WAIT_LOCK
        pll_locked_in = 1'b0;
        n = 0;
        while (lost_lock !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_val("lost_lock_again", lost_lock, 32'd1);
        measure_pulse(n);
        pll_locked_in = 1'b1;
        repeat (6) tick();
        pll_locked_in = 1'b0;
        wait_leave_lock_states(n);
        check_val("timeout_not_reset", n + 6, LTC);
        check_val("timeout_retry", retry_count, 32'd1);
        check_val("timeout_state", state, 32'd0);

        // Synchronous reset in the middle of an attempt
        measure_pulse(n);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("midrst_state", state, 32'd0);
        check_val("midrst_pll_rst", pll_rst, 32'd1);
        check_val("midrst_retry", retry_count, 32'd0);
        check_val("midrst_ready", sys_ready, 32'd0);
        check_val("midrst_lock_fail", lock_fail, 32'd0);
        rst = 1'b0;
        measure_pulse(n);
        check_val("midrst_pulse_len", n, RPC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
